// File: rtl/ram_stream_reader.sv
// Read sequencer for the TPU distributed RAM: turns (base, length) commands into a registered valid/ready word stream.
// Optional macro READER_WRAP_EN: when defined, addresses wrap modulo DATA_DEPTH; when undefined, out-of-range commands pulse o_err.
module ram_stream_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int DATA_DEPTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [ADDRESS_WIDTH-1:0] i_base_addr,
  input  logic [ADDRESS_WIDTH:0]   i_length,
  input  logic                     i_abort,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  output logic [ADDRESS_WIDTH-1:0] o_ram_addr,
  input  logic [DATA_WIDTH-1:0]    i_ram_data,
  output logic [DATA_WIDTH-1:0]    o_m_data,
  output logic                     o_m_valid,
  input  logic                     i_m_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [ADDRESS_WIDTH:0]   r_remaining;
  logic [DATA_WIDTH-1:0]    r_m_data;
  logic                     r_m_valid;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_err;

  logic                     w_slot_free;
  logic                     w_accept;
  logic [ADDRESS_WIDTH-1:0] w_addr_next;

  assign w_slot_free = !r_m_valid || i_m_ready;

`ifdef READER_WRAP_EN
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DATA_DEPTH - 1);

  // Wrap explicitly so non-power-of-two depths also return to address 0.
  assign w_addr_next = (r_addr >= LAST_ADDR) ? '0 : r_addr + 1'b1;
  assign w_accept    = 1'b1;
`else
  localparam logic [ADDRESS_WIDTH+1:0] DEPTH_EXT = (ADDRESS_WIDTH+2)'(DATA_DEPTH);

  logic [ADDRESS_WIDTH+1:0] w_end;

  assign w_end       = {2'b00, i_base_addr} + {1'b0, i_length};
  assign w_accept    = (w_end <= DEPTH_EXT) && ({1'b0, i_length} <= DEPTH_EXT);
  assign w_addr_next = r_addr + 1'b1;
`endif

  assign o_ram_addr = r_addr;
  assign o_m_data   = r_m_data;
  assign o_m_valid  = r_m_valid;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // Abort beats every other transition while a command is active.
      if (i_abort && (r_state != IDLE)) begin
        r_state     <= IDLE;
        r_m_valid   <= 1'b0;
        r_remaining <= '0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_start && !i_abort) begin
              if (i_length == '0) begin
                r_done <= 1'b1;
              end else if (w_accept) begin
                r_addr      <= i_base_addr;
                r_remaining <= i_length;
                r_busy      <= 1'b1;
                r_state     <= RUN;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          RUN: begin
            if (w_slot_free) begin
              r_m_data    <= i_ram_data;
              r_m_valid   <= 1'b1;
              r_addr      <= w_addr_next;
              r_remaining <= r_remaining - 1'b1;
              if (r_remaining == (ADDRESS_WIDTH+1)'(1)) begin
                r_state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (r_m_valid && i_m_ready) begin
              r_m_valid <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: per-cycle vector table plus hand sequences for reset.
// Build with READER_WRAP_EN defined to exercise the wrapping boundary case instead of the reject case.
module tb_ram_stream_reader;

  localparam int DW = 8;
  localparam int DD = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] baseAddr;
  logic [AW:0]   length;
  logic          abortCmd;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] ramData;
  logic [DW-1:0] mData;
  logic          mValid;
  logic          mReady;

  logic [DW-1:0] mem [0:DD-1];

  int total;
  int bad;

  typedef struct {
    logic          start;
    logic          abortCmd;
    logic          ready;
    logic [AW-1:0] baseAddr;
    logic [AW:0]   length;
    logic          expValid;
    logic [DW-1:0] expData;
    logic          expBusy;
    logic          expDone;
    logic          expErr;
    logic [AW-1:0] expAddr;
  } vec_t;

  vec_t vecs[$];

  ram_stream_reader #(
    .DATA_WIDTH(DW),
    .DATA_DEPTH(DD),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(start),
    .i_base_addr(baseAddr),
    .i_length(length),
    .i_abort(abortCmd),
    .o_busy(busy),
    .o_done(done),
    .o_err(err),
    .o_ram_addr(ramAddr),
    .i_ram_data(ramData),
    .o_m_data(mData),
    .o_m_valid(mValid),
    .i_m_ready(mReady)
  );

  // Asynchronous-read RAM model preloaded with mem[i] = i + 0x10.
  assign ramData = mem[ramAddr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addVec(input logic s, input logic a, input logic r, input int b, input int l,
                        input logic ev, input int ed, input logic eb, input logic edn,
                        input logic ee, input int ea);
    vec_t v;
    v.start    = s;
    v.abortCmd = a;
    v.ready    = r;
    v.baseAddr = AW'(b);
    v.length   = (AW+1)'(l);
    v.expValid = ev;
    v.expData  = DW'(ed);
    v.expBusy  = eb;
    v.expDone  = edn;
    v.expErr   = ee;
    v.expAddr  = AW'(ea);
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs on the falling edge, then check the state left by the next rising edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    start    = v.start;
    abortCmd = v.abortCmd;
    mReady   = v.ready;
    baseAddr = v.baseAddr;
    length   = v.length;
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d valid", idx), int'(mValid), int'(v.expValid));
    if (v.expValid)
      checkOutput($sformatf("vec%0d data", idx), int'(mData), int'(v.expData));
    checkOutput($sformatf("vec%0d busy", idx), int'(busy), int'(v.expBusy));
    checkOutput($sformatf("vec%0d done", idx), int'(done), int'(v.expDone));
    checkOutput($sformatf("vec%0d err", idx), int'(err), int'(v.expErr));
    checkOutput($sformatf("vec%0d addr", idx), int'(ramAddr), int'(v.expAddr));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < DD; i++) mem[i] = DW'(i + 16);

    // Basic read: base 3, length 4.
    addVec(1, 0, 1, 3, 4,  0, 0,     1, 0, 0, 3);
    addVec(0, 0, 1, 0, 0,  1, 8'h13, 1, 0, 0, 4);
    addVec(0, 0, 1, 0, 0,  1, 8'h14, 1, 0, 0, 5);
    addVec(0, 0, 1, 0, 0,  1, 8'h15, 1, 0, 0, 6);
    addVec(0, 0, 1, 0, 0,  1, 8'h16, 1, 0, 0, 7);
    addVec(0, 0, 1, 0, 0,  0, 0,     0, 1, 0, 7);
    addVec(0, 0, 1, 0, 0,  0, 0,     0, 0, 0, 7);
    // Backpressure: base 0, length 3, stall after the first beat; a start while busy is ignored.
    addVec(1, 0, 1, 0, 3,  0, 0,     1, 0, 0, 0);
    addVec(0, 0, 1, 0, 0,  1, 8'h10, 1, 0, 0, 1);
    addVec(1, 0, 0, 0, 0,  1, 8'h10, 1, 0, 0, 1);
    addVec(0, 0, 0, 0, 0,  1, 8'h10, 1, 0, 0, 1);
    addVec(0, 0, 1, 0, 0,  1, 8'h11, 1, 0, 0, 2);
    addVec(0, 0, 1, 0, 0,  1, 8'h12, 1, 0, 0, 3);
    addVec(0, 0, 0, 0, 0,  1, 8'h12, 1, 0, 0, 3);
    addVec(0, 0, 1, 0, 0,  0, 0,     0, 1, 0, 3);
    addVec(0, 0, 1, 0, 0,  0, 0,     0, 0, 0, 3);
    // Zero length.
    addVec(1, 0, 1, 9, 0,  0, 0,     0, 1, 0, 3);
    addVec(0, 0, 1, 0, 0,  0, 0,     0, 0, 0, 3);
    // Abort in IDLE wins over start.
    addVec(1, 1, 1, 9, 2,  0, 0,     0, 0, 0, 3);
    // Abort after the second beat, then a single-word command.
    addVec(1, 0, 1, 0, 8,  0, 0,     1, 0, 0, 0);
    addVec(0, 0, 1, 0, 0,  1, 8'h10, 1, 0, 0, 1);
    addVec(0, 0, 1, 0, 0,  1, 8'h11, 1, 0, 0, 2);
    addVec(0, 1, 1, 0, 0,  0, 0,     0, 0, 0, 2);
    addVec(0, 0, 1, 0, 0,  0, 0,     0, 0, 0, 2);
    addVec(1, 0, 1, 5, 1,  0, 0,     1, 0, 0, 5);
    addVec(0, 0, 1, 0, 0,  1, 8'h15, 1, 0, 0, 6);
    addVec(0, 0, 1, 0, 0,  0, 0,     0, 1, 0, 6);
    addVec(0, 0, 1, 0, 0,  0, 0,     0, 0, 0, 6);
`ifdef READER_WRAP_EN
    // Boundary with wrap: addresses 30, 31, 0, 1.
    addVec(1, 0, 1, 30, 4, 0, 0,     1, 0, 0, 30);
    addVec(0, 0, 1, 0, 0,  1, 8'h2E, 1, 0, 0, 31);
    addVec(0, 0, 1, 0, 0,  1, 8'h2F, 1, 0, 0, 0);
    addVec(0, 0, 1, 0, 0,  1, 8'h10, 1, 0, 0, 1);
    addVec(0, 0, 1, 0, 0,  1, 8'h11, 1, 0, 0, 2);
    addVec(0, 0, 1, 0, 0,  0, 0,     0, 1, 0, 2);
    addVec(0, 0, 1, 0, 0,  0, 0,     0, 0, 0, 2);
`else
    // Boundary without wrap: overflowing and oversize commands are rejected; an exact fit is accepted.
    addVec(1, 0, 1, 30, 4, 0, 0,     0, 0, 1, 6);
    addVec(0, 0, 1, 0, 0,  0, 0,     0, 0, 0, 6);
    addVec(1, 0, 1, 0, 33, 0, 0,     0, 0, 1, 6);
    addVec(0, 0, 1, 0, 0,  0, 0,     0, 0, 0, 6);
    addVec(1, 0, 1, 28, 4, 0, 0,     1, 0, 0, 28);
    addVec(0, 0, 1, 0, 0,  1, 8'h2C, 1, 0, 0, 29);
    addVec(0, 0, 1, 0, 0,  1, 8'h2D, 1, 0, 0, 30);
    addVec(0, 0, 1, 0, 0,  1, 8'h2E, 1, 0, 0, 31);
    addVec(0, 0, 1, 0, 0,  1, 8'h2F, 1, 0, 0, 0);
    addVec(0, 0, 1, 0, 0,  0, 0,     0, 1, 0, 0);
    addVec(0, 0, 1, 0, 0,  0, 0,     0, 0, 0, 0);
`endif

    rst      = 1'b1;
    start    = 1'b0;
    abortCmd = 1'b0;
    mReady   = 1'b1;
    baseAddr = '0;
    length   = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset valid", int'(mValid), 0);
    checkOutput("reset data", int'(mData), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset err", int'(err), 0);
    checkOutput("reset addr", int'(ramAddr), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Reset asserted mid-command clears everything immediately, without waiting for a clock edge.
    @(negedge clk);
    start    = 1'b1;
    abortCmd = 1'b0;
    mReady   = 1'b1;
    baseAddr = AW'(10);
    length   = (AW+1)'(5);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst beat valid", int'(mValid), 1);
    checkOutput("midrst beat data", int'(mData), 8'h1A);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst valid", int'(mValid), 0);
    checkOutput("midrst data", int'(mData), 0);
    checkOutput("midrst busy", int'(busy), 0);
    checkOutput("midrst addr", int'(ramAddr), 0);
    @(negedge clk);
    rst = 1'b0;

    // The reader is usable again after reset.
    @(negedge clk);
    start    = 1'b1;
    baseAddr = AW'(1);
    length   = (AW+1)'(1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("postrst valid", int'(mValid), 1);
    checkOutput("postrst data", int'(mData), 8'h11);
    @(posedge clk);
    #1;
    checkOutput("postrst done", int'(done), 1);
    checkOutput("postrst busy", int'(busy), 0);
    checkOutput("postrst drained", int'(mValid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side sequencer for the distributed RAM used as the TPU's weight and activation buffer.
- Accepts a read command (base address, word count) and drives the RAM's asynchronous read address.
- Registers the returned words into a valid/ready output stream, one word per cycle, toward the systolic-array feeders.

Parameters:
- DATA_WIDTH, 8, width of one RAM word / stream word
- DATA_DEPTH, 32, number of RAM words
- ADDRESS_WIDTH, 5, RAM address width; DATA_DEPTH <= 2**ADDRESS_WIDTH

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  command strobe; sampled only in IDLE
- base_addr  input  ADDRESS_WIDTH  first word address of command
- length  input  ADDRESS_WIDTH+1  number of words to read, 0..DATA_DEPTH
- abort  input  1  synchronous cancel of current command
- busy  output  1  high in RUN or DRAIN
- done  output  1  one-cycle pulse when command completes
- err  output  1  one-cycle pulse when a command is rejected (macro-off build only)
- ram_addr  output  ADDRESS_WIDTH  to RAM read address; driven from internal address register
- ram_data  input  DATA_WIDTH  from RAM read data, combinational on ram_addr
- m_data  output  DATA_WIDTH  stream data, registered
- m_valid  output  1  stream valid, registered
- m_ready  input  1  stream ready from consumer

Behaviour:
- Reset values (async on rst high):
  - state=IDLE, address reg=0 (ram_addr=0), remaining=0.
  - m_data=0, m_valid=0, busy=0, done=0, err=0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 and length>0 at edge N: addr<=base_addr, remaining<=length, state<=RUN.
  - start=1 and length=0: done=1 for the cycle after edge N; stay IDLE; no stream beat.
  - start=1 and not accepted (see Optional Feature): err=1 for the cycle after edge N; stay IDLE.
- Output slot is free when m_valid=0 or m_ready=1 (load and consume in the same cycle permitted).
- RUN, at each edge with slot free:
  - m_data<=ram_data, m_valid<=1, addr<=addr+1, remaining<=remaining-1.
  - If remaining==1 before the edge, state<=DRAIN.
- RUN with slot not free: addr, remaining, m_data and m_valid all hold.
- Latency and throughput:
  - First word is valid after edge N+1 (one cycle after command acceptance).
  - Sustained rate is 1 word/cycle while m_ready=1.
- m_valid/m_data stability: once m_valid=1, m_data and m_valid are stable until a cycle with m_ready=1.
- DRAIN: on an edge with m_valid=1 and m_ready=1: m_valid<=0, state<=IDLE, done=1 for the following cycle.
- busy goes low in the same cycle that done is high.
- start while busy: ignored, no err.
- abort=1 at an edge in RUN or DRAIN:
  - state<=IDLE, m_valid<=0, remaining<=0; no done; in-flight word discarded.
  - Takes priority over all other transitions at that edge.
- abort in IDLE: no effect; abort has priority over start at the same edge.
- Address arithmetic: ADDRESS_WIDTH bits; crossing past DATA_DEPTH-1 is governed by the Optional Feature.
- rst asserted mid-command: immediate return to reset values; the command is lost.

Optional Feature:
- Macro: READER_WRAP_EN.
- Defined:
  - Address increments modulo DATA_DEPTH (DATA_DEPTH-1 -> 0), including non-power-of-two depths.
  - Every command with length <= DATA_DEPTH is accepted; err is tied 0.
- Undefined:
  - A command with base_addr+length > DATA_DEPTH, or length > DATA_DEPTH, is rejected with an err pulse and no state change.
  - Accepted commands never wrap.

Test Plan:
- Basic read: RAM preloaded with mem[i]=i+8'h10, m_ready=1, start base=3 len=4 -> m_valid high on 4 consecutive cycles starting 1 cycle after start, data 13,14,15,16; done pulses the cycle after the last beat; busy low with done.
- Backpressure: base=0 len=3, m_ready low on the cycle after the first beat appears -> m_data holds 10 until ready; total 3 beats 10,11,12; no duplicates or drops.
- Zero length: start len=0 -> done pulse next cycle, m_valid stays 0, busy stays 0.
- Abort: base=0 len=8, abort after the 2nd beat -> m_valid drops next edge, no done, return to IDLE; a new start base=5 len=1 then yields single beat 15.
- Boundary, macro on: base=30 len=4, DATA_DEPTH=32 -> data 2E,2F,10,11 (addresses 30,31,0,1).
- Boundary, macro off: same command -> err pulse, no beats, busy=0; then base=28 len=4 -> 2C..2F, done.
